// File: rtl/sm_div_pkg.sv
// Shared types and sign-magnitude helpers for the sequential sm_divider.
// Helpers work on values zero-extended to SM_MAX_W bits; w is the real operand width.
package sm_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SM_MAX_W = 64;

  // True when the magnitude field (bits w-2:0) is zero, so negative zero counts as zero.
  function automatic logic sm_is_zero(input logic [SM_MAX_W-1:0] v, input int w);
    logic [SM_MAX_W-1:0] mask;
    mask = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
    return (v & mask) == '0;
  endfunction

  function automatic logic [SM_MAX_W-1:0] sm_normalize(input logic [SM_MAX_W-1:0] v,
                                                       input int w);
    return sm_is_zero(v, w) ? '0 : v;
  endfunction

endpackage

// File: rtl/sm_divider_if.sv
// Request/result bundle for sm_divider, with the FSM state exposed for observation.
interface sm_divider_if
  import sm_div_pkg::*;
#(
  parameter int WIDTH = 8
);
  // Handshake: start is sampled only while idle or done; a/b are captured on that
  // accepting edge. busy is high throughout CALC, done pulses for exactly one cycle
  // and results plus flags hold until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             dbz;
  logic             sf;
  logic             zf;
  state_t           state;

  modport master (
    output start, a, b,
    input  busy, done, quot, rem, dbz, sf, zf, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, dbz, sf, zf, state
  );
endinterface

// File: rtl/sm_div_step.sv
// One combinational restoring-division iteration on an M-bit magnitude.
module sm_div_step #(
  parameter int M = 7
) (
  input  logic [M-1:0] r,
  input  logic         bit_in,
  input  logic [M-1:0] d,
  output logic [M-1:0] r_next,
  output logic         q
);
  logic [M:0]   r_sh;
  logic [M-1:0] diff;

  // r < d on entry, so a successful subtract always fits back into M bits.
  always_comb begin
    r_sh   = {r, bit_in};
    q      = (r_sh >= {1'b0, d});
    diff   = r_sh[M-1:0] - d;
    r_next = q ? diff : r_sh[M-1:0];
  end
endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude divider: truncated quotient and remainder, one bit per cycle.
module sm_divider
  import sm_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sm_divider_if.slave  bus
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [M-1:0]     dvd;
  logic [M-1:0]     rmd;
  logic [M-1:0]     dvs;
  logic             sa;
  logic             sb;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic             sf_q;
  logic             zf_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic             b_zero;
  logic [WIDTH-1:0] a_norm;
  logic [M-1:0]     rmd_next;
  logic             q_bit;
  logic [M-1:0]     quot_mag;
  logic             quot_sign;

  assign b_zero    = sm_is_zero(SM_MAX_W'(bus.b), WIDTH);
  assign a_norm    = WIDTH'(sm_normalize(SM_MAX_W'(bus.a), WIDTH));
  // Quotient bits enter dvd from the right as dividend bits leave from the left.
  assign quot_mag  = {dvd[M-2:0], q_bit};
  assign quot_sign = (sa ^ sb) & (|quot_mag);

  sm_div_step #(.M(M)) u_step (
    .r      (rmd),
    .bit_in (dvd[M-1]),
    .d      (dvs),
    .r_next (rmd_next),
    .q      (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      rmd    <= '0;
      dvs    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      sf_q   <= 1'b0;
      zf_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start && b_zero) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dbz_q  <= 1'b1;
            sf_q   <= 1'b0;
            zf_q   <= 1'b1;
            quot_q <= '0;
            rem_q  <= a_norm;
          end else if (bus.start) begin
            state  <= CALC;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            cnt    <= CW'(WIDTH - 1);
            dvd    <= bus.a[M-1:0];
            rmd    <= '0;
            dvs    <= bus.b[M-1:0];
            sa     <= bus.a[WIDTH-1];
            sb     <= bus.b[WIDTH-1];
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        CALC: begin
          dvd <= quot_mag;
          rmd <= rmd_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dbz_q  <= 1'b0;
            sf_q   <= quot_sign;
            zf_q   <= ~(|quot_mag);
            quot_q <= {quot_sign, quot_mag};
            rem_q  <= {sa & (|rmd_next), rmd_next};
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dbz   = dbz_q;
  assign bus.sf    = sf_q;
  assign bus.zf    = zf_q;
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_q;
  assign bus.state = state;
endmodule

// File: tb/tb_sm_divider.sv
// Directed bench for sm_divider at WIDTH=8: timing, sign rules, divide-by-zero, overlap, reset.
module tb_sm_divider;
  import sm_div_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  sm_divider_if #(.WIDTH(W)) bus ();

  sm_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Present a request so it is accepted on the next rising edge, then scramble a/b.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 255));
    bus.b     = W'($urandom_range(0, 255));
  endtask

  // Counts cycles (sampled on falling edges) until done, bounded at 20 cycles.
  task automatic wait_done(input int lat0, input int busy0,
                           output int lat, output int busy_n, output bit ok);
    lat = lat0; busy_n = busy0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.dbz, bus.sf, bus.zf} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.busy, bus.done, bus.dbz, bus.sf, bus.zf});
    end
    checks++;
    if (bus.quot !== 8'h00 || bus.rem !== 8'h00) begin
      failures++;
      $display("FAIL reset_results: got quot=%h rem=%h want 00/00", bus.quot, bus.rem);
    end
    checks++;
    if (bus.state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d want %0d", bus.state, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_positive();
    int lat, busy_n;
    bit ok;
    start_op(8'h64, 8'h07);
    wait_done(0, 0, lat, busy_n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL pos_timeout: got no done want done within 20 cycles");
    end
    checks++;
    if (lat !== 8 || busy_n !== 7) begin
      failures++;
      $display("FAIL pos_timing: got lat=%0d busy=%0d want lat=8 busy=7", lat, busy_n);
    end
    checks++;
    if (bus.quot !== 8'h0E || bus.rem !== 8'h02) begin
      failures++;
      $display("FAIL pos_result: got quot=%h rem=%h want 0e/02", bus.quot, bus.rem);
    end
    checks++;
    if ({bus.sf, bus.zf, bus.dbz} !== 3'b000) begin
      failures++;
      $display("FAIL pos_flags: got sf/zf/dbz=%b want 000", {bus.sf, bus.zf, bus.dbz});
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.state !== IDLE || bus.quot !== 8'h0E) begin
      failures++;
      $display("FAIL pos_after: got done=%b state=%0d quot=%h want 0/%0d/0e",
               bus.done, bus.state, bus.quot, IDLE);
    end
  endtask

  task automatic test_signs();
    logic [W-1:0] va [3] = '{8'hE4, 8'hFF, 8'h2D};
    logic [W-1:0] vb [3] = '{8'h07, 8'h81, 8'h86};
    logic [W-1:0] eq [3] = '{8'h8E, 8'h7F, 8'h87};
    logic [W-1:0] er [3] = '{8'h82, 8'h00, 8'h03};
    logic         es [3] = '{1'b1, 1'b0, 1'b1};
    int lat, busy_n;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      start_op(va[k], vb[k]);
      wait_done(0, 0, lat, busy_n, ok);
      checks++;
      if (!ok || lat !== 8) begin
        failures++;
        $display("FAIL signs_timing[%0d]: got ok=%b lat=%0d want 1/8", k, ok, lat);
      end
      checks++;
      if (bus.quot !== eq[k] || bus.rem !== er[k]) begin
        failures++;
        $display("FAIL signs_result[%0d]: got quot=%h rem=%h want %h/%h",
                 k, bus.quot, bus.rem, eq[k], er[k]);
      end
      checks++;
      if (bus.sf !== es[k] || bus.zf !== 1'b0 || bus.dbz !== 1'b0) begin
        failures++;
        $display("FAIL signs_flags[%0d]: got sf=%b zf=%b dbz=%b want %b/0/0",
                 k, bus.sf, bus.zf, bus.dbz, es[k]);
      end
    end
  endtask

  task automatic test_zero_quot();
    int lat, busy_n;
    bit ok;
    start_op(8'h85, 8'h09);
    wait_done(0, 0, lat, busy_n, ok);
    checks++;
    if (!ok || bus.quot !== 8'h00 || bus.rem !== 8'h85) begin
      failures++;
      $display("FAIL zeroq_result: got ok=%b quot=%h rem=%h want 1/00/85",
               ok, bus.quot, bus.rem);
    end
    checks++;
    if (bus.zf !== 1'b1 || bus.sf !== 1'b0) begin
      failures++;
      $display("FAIL zeroq_flags: got zf=%b sf=%b want 1/0", bus.zf, bus.sf);
    end
  endtask

  task automatic test_dbz();
    logic [W-1:0] vb [2] = '{8'h80, 8'h00};
    int lat, busy_n;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      start_op(8'h23, vb[k]);
      wait_done(0, 0, lat, busy_n, ok);
      checks++;
      if (!ok || lat !== 1 || busy_n !== 0) begin
        failures++;
        $display("FAIL dbz_timing[%0d]: got ok=%b lat=%0d busy=%0d want 1/1/0",
                 k, ok, lat, busy_n);
      end
      checks++;
      if (bus.dbz !== 1'b1 || bus.quot !== 8'h00 || bus.rem !== 8'h23) begin
        failures++;
        $display("FAIL dbz_result[%0d]: got dbz=%b quot=%h rem=%h want 1/00/23",
                 k, bus.dbz, bus.quot, bus.rem);
      end
      checks++;
      if (bus.zf !== 1'b1 || bus.sf !== 1'b0) begin
        failures++;
        $display("FAIL dbz_flags[%0d]: got zf=%b sf=%b want 1/0", k, bus.zf, bus.sf);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, busy_n;
    bit ok;
    start_op(8'h64, 8'h07);
    lat = 0; busy_n = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 2 || lat == 4);
      bus.a     = 8'h10;
      bus.b     = 8'h03;
      if (bus.busy) busy_n++;
      if (bus.done) ok = 1'b1;
    end
    bus.start = 1'b0;
    checks++;
    if (!ok || lat !== 8 || busy_n !== 7) begin
      failures++;
      $display("FAIL ign_timing: got ok=%b lat=%0d busy=%0d want 1/8/7", ok, lat, busy_n);
    end
    checks++;
    if (bus.quot !== 8'h0E || bus.rem !== 8'h02 || bus.dbz !== 1'b0) begin
      failures++;
      $display("FAIL ign_result: got quot=%h rem=%h dbz=%b want 0e/02/0",
               bus.quot, bus.rem, bus.dbz);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    bit ok;
    start_op(8'h64, 8'h07);
    wait_done(0, 0, lat, busy_n, ok);
    checks++;
    if (!ok || bus.quot !== 8'h0E || bus.rem !== 8'h02) begin
      failures++;
      $display("FAIL b2b_first: got ok=%b quot=%h rem=%h want 1/0e/02",
               ok, bus.quot, bus.rem);
    end
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h03;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0/1", bus.done, bus.busy);
    end
    wait_done(1, 1, lat, busy_n, ok);
    checks++;
    if (!ok || lat !== 8 || busy_n !== 7) begin
      failures++;
      $display("FAIL b2b_timing: got ok=%b lat=%0d busy=%0d want 1/8/7", ok, lat, busy_n);
    end
    checks++;
    if (bus.quot !== 8'h05 || bus.rem !== 8'h01) begin
      failures++;
      $display("FAIL b2b_second: got quot=%h rem=%h want 05/01", bus.quot, bus.rem);
    end
  endtask

  task automatic test_async_reset();
    int lat, busy_n, done_seen;
    bit ok;
    start_op(8'h64, 8'h07);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.dbz, bus.sf, bus.zf} !== 5'b0 || bus.state !== IDLE) begin
      failures++;
      $display("FAIL arst_flags: got bdxsz=%b state=%0d want 00000/%0d",
               {bus.busy, bus.done, bus.dbz, bus.sf, bus.zf}, bus.state, IDLE);
    end
    checks++;
    if (bus.quot !== 8'h00 || bus.rem !== 8'h00) begin
      failures++;
      $display("FAIL arst_results: got quot=%h rem=%h want 00/00", bus.quot, bus.rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL arst_no_done: got %0d active cycles want 0", done_seen);
    end
    start_op(8'h7F, 8'h02);
    wait_done(0, 0, lat, busy_n, ok);
    checks++;
    if (!ok || lat !== 8 || bus.quot !== 8'h3F || bus.rem !== 8'h01) begin
      failures++;
      $display("FAIL arst_fresh: got ok=%b lat=%0d quot=%h rem=%h want 1/8/3f/01",
               ok, lat, bus.quot, bus.rem);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_positive();
    test_signs();
    test_zero_quot();
    test_dbz();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
